delay_tap_sequencer: RTL and testbench
======================================

# delay_tap_sequencer

Sequences a 512×16 simple-dual-port block RAM (the `ram2_512` class of primitive) as a circular microphone delay line for delay-and-sum beamforming. Each accepted PCM sample is written at the write pointer. The block then issues one read per steering tap at `write_address − delay[k]` (mod 512) and streams the tap samples to the downstream beam accumulator. It sits between a mic channel's decimated PCM stream and the summing stage, one instance per RAM.

## Interface
Parameters:
- `ADDR_W`, 9, RAM address width; depth is 2^ADDR_W = 512.
- `DATA_W`, 16, sample width (two's complement).
- `NTAP`, 8, number of steering taps read per sample.
- `TAP_W`, 3, tap index width, equal to clog2(NTAP).

Ports:
- `clk`  in  1  single clock for the block and both RAM ports.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  an input sample is present.
- `in_data`  in  DATA_W  input PCM sample.
- `in_ready`  out  1  block can accept a sample; high only in IDLE.
- `dly_we`  in  1  write strobe for the delay table.
- `dly_idx`  in  TAP_W  index of the delay-table entry being written.
- `dly_val`  in  ADDR_W  delay value in samples, 0..511.
- `ram_cea`  out  1  RAM write-port enable.
- `ram_ada`  out  ADDR_W  RAM write address.
- `ram_din`  out  DATA_W  RAM write data.
- `ram_ceb`  out  1  RAM read-port enable.
- `ram_adb`  out  ADDR_W  RAM read address.
- `ram_oce`  out  1  RAM output-register enable; tied to 1.
- `ram_dout`  in  DATA_W  RAM read data. The RAM runs in bypass read mode: data is valid 1 cycle after the read is issued.
- `tap_valid`  out  1  one-cycle strobe marking a valid tap sample.
- `tap_idx`  out  TAP_W  tap number for the current strobe.
- `tap_data`  out  DATA_W  tap sample; forced to 0 when the tap is not yet filled.
- `tap_last`  out  1  asserted together with `tap_valid` on tap NTAP−1.

## Operation
- State is 2-valued: IDLE and READ.
- Registers:
  - `wp` (ADDR_W): write pointer, reset 0.
  - `base` (ADDR_W): the address of the last write.
  - `k` (TAP_W): tap counter.
  - `fill` (ADDR_W+1 bits): samples written, saturating at 512.
  - `dly[NTAP]`: live delay table, reset 0.
  - `shd[NTAP]`: shadow copy of the delay table.
- Accept occurs when `in_valid & in_ready`, in IDLE only. On accept, in the same cycle:
  - Combinational write: `ram_cea=1`, `ram_ada=wp`, `ram_din=in_data`.
  - Registered: `base<=wp`, `wp<=wp+1`. Wrap 511→0 is natural modulo-512 arithmetic.
  - `fill<=min(fill+1,512)`.
  - `shd<=dly`.
  - `k<=0`, transition to READ.
- READ, each cycle:
  - `ram_ceb=1`, `ram_adb=(base−shd[k]) mod 2^ADDR_W`.
  - Register the pipeline stage: `k`, `zero=(shd[k] >= fill)`, last=(k==NTAP−1).
  - Increment `k`. After k=NTAP−1, go to IDLE.
- Output stage, one cycle after each read:
  - `tap_valid=1`, `tap_idx`=registered k.
  - `tap_data = zero ? 0 : ram_dout`.
  - `tap_last` asserted with tap NTAP−1.
- Fill gating: delay d requires d+1 stored samples. Since `fill` already counts the current sample, the tap is gated when d ≥ fill. This hides stale RAM contents after reset.
- Config writes (`dly_we`):
  - Update `dly[dly_idx]` at any time.
  - They never affect a sequence in progress, which uses `shd`.
  - A write in the same cycle as an accept is not seen by that sample's sequence (shd takes the pre-write value). It takes effect on the next sample.
- `in_valid` while not ready: the sample is held by the upstream, not dropped. Upstream must hold it until `in_ready`.
- There is no backpressure on the tap outputs; the downstream must sink 1 tap per cycle.

## Timing
- Reset values:
  - `in_ready=1` (IDLE).
  - `ram_cea=0`, `ram_ceb=0`, `ram_ada=0`, `ram_adb=0`, `ram_din=0`, `ram_oce=1`.
  - `tap_valid=0`, `tap_idx=0`, `tap_data=0`, `tap_last=0`.
- Per-sample timeline, with the accept in cycle 0:
  - Cycle 0: write.
  - Cycles 1..NTAP: reads.
  - Cycles 2..NTAP+1: tap outputs.
  - `in_ready` high again in cycle NTAP+1.
- Maximum throughput is one sample per NTAP+1 = 9 cycles. A new accept in cycle 9 overlaps the tap-7 output, which is legal because write and read ports are independent.
- Delay 0 reads the address written in cycle 0 from cycle 1 onward: read-after-write across cycles, so there is no collision.
- Reset mid-READ:
  - Next cycle is IDLE, all pointers and counters are 0, `dly`/`shd` are 0.
  - Any in-flight `tap_valid` is suppressed.
  - RAM contents are untouched; fill gating hides them.

## Structure
- Package `beam_pkg`:
  - `ADDR_W`, `DATA_W`, `NTAP`, `TAP_W`.
  - The `seq_state_t` enum {IDLE, READ}.
  - Typedefs `addr_t`, `sample_t`.
- Sub-module `delay_tap_regs`: the live and shadow delay tables. Inputs: `dly_we`/`dly_idx`/`dly_val`, a load strobe, and the tap index k. Output: `shd[k]`.
- The top level contains the FSM, pointers, fill counter and output stage.

## Test plan
- Reset, dly all 0, accept 0x1234 → one write at ada=0; taps 0..7 appear in cycles 2..9 with data 0x1234; `tap_last` at tap 7; `in_ready` high in cycle 9.
- dly[3]=5, write ramp 0..9 → on sample 9 (base=9), tap 3 reads adb=4 and returns 4. Before 6 samples are written, tap 3 outputs 0.
- 515 back-to-back samples with dly[0]=5 → on sample 515, base wraps to 2 and tap 0 reads adb=509; `fill` saturates at 512.
- `dly_we` in the same cycle as an accept → that sequence uses the old delay; the next sample uses the new one.
- `in_valid` held high continuously → accepts exactly every 9 cycles; `ram_cea` is never asserted while in READ.
- `reset` at READ k=4 → no further `tap_valid`; `wp=0`, `fill=0`; the next sample after reset yields zeros on every tap with d>0.

Source files
------------

// File: rtl/beam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : beam_pkg
//  Description : Shared sizes, state encoding and types for the beamforming
//                delay-line sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package beam_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int NTAP   = 8;
    localparam int TAP_W  = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } seq_state_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/delay_tap_regs.sv
`default_nettype none
// ============================================================================
//  Module      : delay_tap_regs
//  Description : Live steering-delay table plus a shadow copy that is frozen
//                on each accepted sample, so reconfiguration never disturbs
//                a read sequence already under way.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_tap_regs
    import beam_pkg::*;
#(
    parameter int ADDR_W = beam_pkg::ADDR_W,
    parameter int NTAP   = beam_pkg::NTAP,
    parameter int TAP_W  = beam_pkg::TAP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_dly_we,
    input  logic [TAP_W-1:0]  i_dly_idx,
    input  logic [ADDR_W-1:0] i_dly_val,
    input  logic              i_load,
    input  logic [TAP_W-1:0]  i_k,
    output logic [ADDR_W-1:0] o_shd_k
);

    logic [ADDR_W-1:0] r_dly [NTAP];
    logic [ADDR_W-1:0] r_shd [NTAP];

    // Live table: host writes land here at any time.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) begin
                r_dly[i] <= '0;
            end
        end else if (i_dly_we) begin
            r_dly[i_dly_idx] <= i_dly_val;
        end
    end

    // Shadow table: snapshots the pre-write live values on accept, so a
    // same-cycle host write only takes effect from the following sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) begin
                r_shd[i] <= '0;
            end
        end else if (i_load) begin
            for (int i = 0; i < NTAP; i++) begin
                r_shd[i] <= r_dly[i];
            end
        end
    end

    assign o_shd_k = r_shd[i_k];

endmodule
`default_nettype wire

// File: rtl/delay_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : delay_tap_sequencer
//  Description : Drives a 512x16 simple-dual-port RAM as a circular delay
//                line: writes each accepted sample, then issues one read per
//                steering tap at (write address - delay) and streams the tap
//                samples out, zeroing taps that reach past the filled history.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_tap_sequencer
    import beam_pkg::*;
#(
    parameter int ADDR_W = beam_pkg::ADDR_W,
    parameter int DATA_W = beam_pkg::DATA_W,
    parameter int NTAP   = beam_pkg::NTAP,
    parameter int TAP_W  = beam_pkg::TAP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              dly_we,
    input  logic [TAP_W-1:0]  dly_idx,
    input  logic [ADDR_W-1:0] dly_val,
    output logic              ram_cea,
    output logic [ADDR_W-1:0] ram_ada,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_ceb,
    output logic [ADDR_W-1:0] ram_adb,
    output logic              ram_oce,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              tap_valid,
    output logic [TAP_W-1:0]  tap_idx,
    output logic [DATA_W-1:0] tap_data,
    output logic              tap_last
);

    localparam logic [TAP_W-1:0] c_last_k   = TAP_W'(NTAP - 1);
    localparam logic [ADDR_W:0]  c_fill_max = (ADDR_W+1)'(1) << ADDR_W;

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              w_accept;
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_base;
    logic [TAP_W-1:0]  r_k;
    logic [ADDR_W:0]   r_fill;
    logic [ADDR_W-1:0] w_shd_k;

    // Output-stage pipeline: tracks the read issued in the previous cycle.
    logic              r_p_valid;
    logic [TAP_W-1:0]  r_p_k;
    logic              r_p_zero;
    logic              r_p_last;

    delay_tap_regs #(
        .ADDR_W (ADDR_W),
        .NTAP   (NTAP),
        .TAP_W  (TAP_W)
    ) u_regs (
        .clk       (clk),
        .rst       (reset),
        .i_dly_we  (dly_we),
        .i_dly_idx (dly_idx),
        .i_dly_val (dly_val),
        .i_load    (w_accept),
        .i_k       (r_k),
        .o_shd_k   (w_shd_k)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus RAM port controls: write on accept, one read per tap.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        in_ready    = 1'b0;
        ram_ceb     = 1'b0;
        ram_adb     = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                ram_ceb = 1'b1;
                // Modulo-2^ADDR_W subtraction walks backwards round the ring.
                ram_adb = r_base - w_shd_k;
                if (r_k == c_last_k) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign ram_cea = w_accept;
    assign ram_ada = w_accept ? r_wp    : '0;
    assign ram_din = w_accept ? in_data : '0;
    assign ram_oce = 1'b1;

    // Pointers, tap counter and saturating fill count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp   <= '0;
            r_base <= '0;
            r_k    <= '0;
            r_fill <= '0;
        end else if (w_accept) begin
            r_base <= r_wp;
            r_wp   <= r_wp + 1'b1;
            r_k    <= '0;
            if (r_fill != c_fill_max) begin
                r_fill <= r_fill + 1'b1;
            end
        end else if (r_state == READ) begin
            r_k <= r_k + 1'b1;
        end
    end

    // Tag each read so its data can be labelled/gated when RAM returns it.
    // A delay d needs d+1 stored samples; fill already counts this sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_valid <= 1'b0;
            r_p_k     <= '0;
            r_p_zero  <= 1'b0;
            r_p_last  <= 1'b0;
        end else begin
            r_p_valid <= (r_state == READ);
            r_p_k     <= r_k;
            r_p_zero  <= ({1'b0, w_shd_k} >= r_fill);
            r_p_last  <= (r_state == READ) && (r_k == c_last_k);
        end
    end

    assign tap_valid = r_p_valid;
    assign tap_idx   = r_p_k;
    assign tap_last  = r_p_last;
    assign tap_data  = (r_p_valid && !r_p_zero) ? ram_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_delay_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_tap_sequencer
//  Description : Self-checking bench: behavioural RAM, ring-buffer reference
//                model with timed scoreboard, directed tables and sequences,
//                and a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_tap_sequencer;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data  = '0;
    logic        dly_we   = 1'b0;
    logic [2:0]  dly_idx  = '0;
    logic [8:0]  dly_val  = '0;
    logic        in_ready, ram_cea, ram_ceb, ram_oce, tap_valid, tap_last;
    logic [8:0]  ram_ada, ram_adb;
    logic [15:0] ram_din, ram_dout, tap_data;
    logic [2:0]  tap_idx;

    int checks   = 0;
    int failures = 0;

    delay_tap_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .dly_we    (dly_we),
        .dly_idx   (dly_idx),
        .dly_val   (dly_val),
        .ram_cea   (ram_cea),
        .ram_ada   (ram_ada),
        .ram_din   (ram_din),
        .ram_ceb   (ram_ceb),
        .ram_adb   (ram_adb),
        .ram_oce   (ram_oce),
        .ram_dout  (ram_dout),
        .tap_valid (tap_valid),
        .tap_idx   (tap_idx),
        .tap_data  (tap_data),
        .tap_last  (tap_last)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: bypass read, data one cycle after the read enable.
    logic [15:0] ram [512];
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 16'($urandom);
    end
    always @(posedge clk) begin
        if (ram_cea) ram[ram_ada] <= ram_din;
        if (ram_ceb) ram_dout <= ram[ram_adb];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + timed scoreboard ----------------
    typedef struct { int cyc; int adr; } rd_t;
    typedef struct { int cyc; int idx; int data; bit last; } tp_t;
    rd_t rq[$];
    tp_t tq[$];
    int  cyc        = 0;
    int  m_wp       = 0;
    int  m_fill     = 0;
    int  m_ready_at = 0;
    int  m_dly [8];
    int  m_mem [512];
    int  obs_data [8];

    always @(negedge clk) begin
        bit acc;
        int a;
        int d;
        cyc++;
        if (reset) begin
            m_wp = 0; m_fill = 0; m_ready_at = cyc + 1;
            for (int k = 0; k < 8; k++) m_dly[k] = 0;
            rq.delete(); tq.delete();
        end else begin
            acc = in_valid && (cyc >= m_ready_at);
            chk("in_ready", int'(in_ready), int'(cyc >= m_ready_at));
            chk("ram_cea", int'(ram_cea), int'(acc));
            chk("cea_during_read", int'(ram_cea && ram_ceb), 0);
            if (acc) begin
                chk("ram_ada", int'(ram_ada), m_wp);
                chk("ram_din", int'(ram_din), int'(in_data));
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                chk("ram_ceb", int'(ram_ceb), 1);
                chk("ram_adb", int'(ram_adb), rq[0].adr);
                void'(rq.pop_front());
            end else begin
                chk("ram_ceb_idle", int'(ram_ceb), 0);
            end
            if (tq.size() > 0 && tq[0].cyc == cyc) begin
                chk("tap_valid", int'(tap_valid), 1);
                chk("tap_idx", int'(tap_idx), tq[0].idx);
                chk("tap_data", int'(tap_data), tq[0].data);
                chk("tap_last", int'(tap_last), int'(tq[0].last));
                void'(tq.pop_front());
            end else begin
                chk("tap_valid_idle", int'(tap_valid), 0);
            end
            if (tap_valid) obs_data[tap_idx] = int'(tap_data);
            if (acc) begin
                m_mem[m_wp] = int'(in_data);
                m_fill = (m_fill + 1 > 512) ? 512 : m_fill + 1;
                for (int k = 0; k < 8; k++) begin
                    d = m_dly[k];
                    a = (m_wp - d) & 511;
                    rq.push_back('{cyc: cyc + 1 + k, adr: a});
                    tq.push_back('{cyc: cyc + 2 + k, idx: k,
                                   data: (d >= m_fill) ? 0 : m_mem[a], last: (k == 7)});
                end
                m_wp = (m_wp + 1) % 512;
                m_ready_at = cyc + 9;
            end
            if (dly_we) m_dly[dly_idx] = int'(dly_val);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; dly_we = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic set_dly(input int idx, input int val);
        dly_we = 1'b1; dly_idx = 3'(idx); dly_val = 9'(val);
        tick();
        dly_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        chk("ready_timeout", int'(in_ready), 1);
    endtask

    task automatic send(input int d);
        wait_ready();
        in_valid = 1'b1; in_data = 16'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (12) tick();
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 8; k++) obs_data[k] = -1;
    endtask

    typedef struct { int idx; int dval; int nsamp; int exp_data; } vec_t;

    initial begin
        int   acc_cyc [$];
        bit   hold;
        vec_t vt [8];

        // {tap, delay, ramp samples 100.., expected data on tap of last sample}
        vt = '{'{3, 5, 10, 104}, '{3, 5, 5, 0},   '{3, 5, 6, 100}, '{7, 0, 3, 102},
               '{1, 2, 3, 100},  '{1, 3, 3, 0},   '{5, 511, 4, 0}, '{0, 1, 2, 100}};

        // Reset values and single sample with all delays 0.
        do_reset();
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_cea", int'(ram_cea), 0);
        chk("rst_ceb", int'(ram_ceb), 0);
        chk("rst_ada", int'(ram_ada), 0);
        chk("rst_adb", int'(ram_adb), 0);
        chk("rst_din", int'(ram_din), 0);
        chk("rst_oce", int'(ram_oce), 1);
        chk("rst_tap_valid", int'(tap_valid), 0);
        chk("rst_tap_idx", int'(tap_idx), 0);
        chk("rst_tap_data", int'(tap_data), 0);
        chk("rst_tap_last", int'(tap_last), 0);
        tick();
        in_valid = 1'b1; in_data = 16'h1234;
        #1;
        chk("c0_cea", int'(ram_cea), 1);
        chk("c0_ada", int'(ram_ada), 0);
        chk("c0_din", int'(ram_din), 16'h1234);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            #1;
            chk("seq_in_ready", int'(in_ready), int'(c == 9));
            chk("seq_tap_valid", int'(tap_valid), int'(c >= 2));
            if (c >= 2) begin
                chk("seq_tap_idx", int'(tap_idx), c - 2);
                chk("seq_tap_data", int'(tap_data), 16'h1234);
                chk("seq_tap_last", int'(tap_last), int'(c == 9));
            end
            tick();
        end

        // Table: single delay, ramp history, probe one tap incl. fill gating.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            set_dly(vt[t].idx, vt[t].dval);
            for (int s = 0; s < vt[t].nsamp; s++) begin
                if (s == vt[t].nsamp - 1) clear_obs();
                send(100 + s);
            end
            drain();
            chk("tbl_tap", obs_data[vt[t].idx], vt[t].exp_data);
        end

        // Wrap-around with saturating fill.
        do_reset();
        set_dly(0, 5);
        set_dly(1, 511);
        for (int n = 1; n <= 514; n++) send(n);
        clear_obs();
        send(515);
        #1;
        chk("wrap_adb", int'(ram_adb), 509);
        drain();
        chk("wrap_tap0", obs_data[0], 510);
        chk("wrap_tap1_sat", obs_data[1], 4);

        // Delay write coincident with accept takes effect on the next sample.
        do_reset();
        send(16'h1111);
        wait_ready();
        clear_obs();
        in_valid = 1'b1; in_data = 16'hAAAA;
        dly_we = 1'b1; dly_idx = 3'd2; dly_val = 9'd1;
        tick();
        in_valid = 1'b0; dly_we = 1'b0;
        drain();
        chk("samecyc_old", obs_data[2], 16'hAAAA);
        clear_obs();
        send(16'hBBBB);
        drain();
        chk("samecyc_new", obs_data[2], 16'hAAAA);
        chk("samecyc_tap0", obs_data[0], 16'hBBBB);

        // Continuous valid: accepts exactly every 9 cycles.
        do_reset();
        in_valid = 1'b1; in_data = 16'h0C0C;
        for (int c = 0; c < 45; c++) begin
            #1;
            if (ram_cea) acc_cyc.push_back(c);
            tick();
        end
        in_valid = 1'b0;
        chk("cont_count", acc_cyc.size(), 5);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("cont_gap", acc_cyc[i] - acc_cyc[i-1], 9);
        drain();

        // Reset while reading tap 4.
        do_reset();
        set_dly(0, 3);
        send(16'h5555);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("midrst_tap_valid", int'(tap_valid), 0);
            chk("midrst_in_ready", int'(in_ready), 1);
            tick();
        end
        for (int k = 0; k < 8; k++) set_dly(k, k);
        clear_obs();
        send(16'h7777);
        drain();
        for (int k = 0; k < 8; k++)
            chk("midrst_tap", obs_data[k], (k == 0) ? 16'h7777 : 0);

        // Randomized traffic, config writes and occasional resets.
        do_reset();
        hold = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 99) < 50);
                in_data  = 16'($urandom);
            end
            dly_we  = ($urandom_range(0, 9) == 0);
            dly_idx = 3'($urandom);
            dly_val = $urandom_range(0, 1) ? 9'($urandom_range(0, 12)) : 9'($urandom);
            reset   = ($urandom_range(0, 399) == 0);
            if (reset) begin in_valid = 1'b0; dly_we = 1'b0; end
            hold = in_valid && !in_ready;
            tick();
        end
        reset = 1'b0; in_valid = 1'b0; dly_we = 1'b0;
        drain();
        chk("pending_taps", tq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
